// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants, LSU state encoding and decode helpers.
// Imported by the ALU, decoder and load/store unit.
package mips_pkg;

  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic op_byte(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_SB);
  endfunction

  function automatic logic op_half(input logic [5:0] op);
    return (op == OP_LH) || (op == OP_SH);
  endfunction

  function automatic logic op_word(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return op_byte(op) || op_half(op) || op_word(op);
  endfunction

  function automatic logic op_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic misaligned(
    input logic [5:0] op,
    input logic [1:0] off
  );
    return (op_half(op) && off[0]) ||
           (op_word(op) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load
// lane extract with sign extension.
module lsu_align
  import mips_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b  = rdata_i[{off_i, 3'b000} +: 8];
    lane_h  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o    = 4'b0000;
    wdata_o = st_data_i;
    ldata_o = rdata_i;
    unique case (1'b1)
      op_byte(op_i): begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{st_data_i[7:0]}};
        ldata_o = {{24{lane_b[7]}}, lane_b};
      end
      op_half(op_i): begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
        ldata_o = {{16{lane_h[15]}}, lane_h};
      end
      op_word(op_i): begin
        be_o    = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit: IDLE/REQ/DONE FSM driving a single-beat
// request/ack memory port with registered request fields.
module load_store_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] rt_reg,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_q, ld_d;

  logic        idle, accept, mis, ack_ok;
  logic [5:0]  al_op;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ldata;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle && start && op_legal(opcode);
  assign mis    = misaligned(opcode, addr[1:0]);
  assign ack_ok = (state_q == ST_REQ) && mem_ack;

  // Live request steers stores; latched request steers load extract.
  assign al_op  = idle ? opcode : op_q;
  assign al_off = idle ? addr[1:0] : off_q;

  lsu_align u_align (
    .op_i      (al_op),
    .off_i     (al_off),
    .st_data_i (rt_reg),
    .rdata_i   (mem_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .ldata_o   (al_ldata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = mis ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_ack) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = !idle;
    done     = (state_q == ST_DONE);
    addr_err = (state_q == ST_DONE) && err_q;
  end

  always_comb begin
    op_d    = op_q;
    off_d   = off_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    if (accept) begin
      op_d  = opcode;
      off_d = addr[1:0];
      err_d = mis;
      if (!mis) begin
        req_d   = 1'b1;
        we_d    = op_store(opcode);
        addr_d  = {addr[31:2], 2'b00};
        be_d    = al_be;
        wdata_d = al_wdata;
      end
    end else if (ack_ok) begin
      req_d = 1'b0;
      if (!we_q) ld_d = al_ldata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      off_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
    end else begin
      op_q    <= op_d;
      off_q   <= off_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign load_data = ld_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with
// scoreboard plus hand sequences for overlap, illegal op, reset.
`timescale 1ns/1ps
module tb_load_store_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] addr = '0;
  logic [31:0] rt_reg = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy, done, addr_err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  load_store_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .addr      (addr),
    .rt_reg    (rt_reg),
    .busy      (busy),
    .done      (done),
    .load_data (load_data),
    .addr_err  (addr_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int   ntests = 0;
  int   nfail = 0;
  int   req_cnt = 0;
  int   done_cnt = 0;
  logic req_prev = 1'b0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          dly;
    logic        err;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
    int          lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] ld;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];

  // Transaction monitor, sampled just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (mem_req && !req_prev) req_cnt++;
    req_prev = mem_req;
    if (done) done_cnt++;
  end

  function automatic void chk(input string n,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  task automatic run(input vec_t v);
    int   cyc;
    int   rc;
    int   r0;
    int   d0;
    exp_t e;
    e.err = v.err;
    e.ld  = v.ld;
    sb.push_back(e);
    r0 = req_cnt;
    d0 = done_cnt;
    @(negedge clk);
    start  = 1'b1;
    opcode = v.op;
    addr   = v.a;
    rt_reg = v.rt;
    @(negedge clk);
    start  = 1'b0;
    rt_reg = 32'h0BAD_0BAD;
    cyc = 1;
    rc  = 0;
    while (!done && cyc < 20) begin
      if (mem_req) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, v.we});
        chk("mem_addr", mem_addr, v.maddr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, v.be});
        if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
        if (rc == v.dly) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
        rc++;
      end
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
      cyc++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("latency", cyc, v.lat);
    chk("busy_done", {31'd0, busy}, 32'd1);
    chk("req_off_done", {31'd0, mem_req}, 32'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
      chk("load_data", load_data, e.ld);
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("req_count", req_cnt - r0, v.err ? 0 : 1);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    logic [31:0] ld_exp;
    int r0;
    int d0;
    exp_t e;

    tbl[0]  = '{OP_LB, 32'h1003, 32'h0, 32'h80AABBCC, 3, 1'b0, 1'b0,
                32'h1000, 4'b1000, 32'h0, 32'hFFFFFF80, 5};
    tbl[1]  = '{OP_SH, 32'h2002, 32'h12345678, 32'h0, 0, 1'b0, 1'b1,
                32'h2000, 4'b1100, 32'h56785678, 32'hFFFFFF80, 2};
    tbl[2]  = '{OP_LW, 32'h3001, 32'h0, 32'h0, 0, 1'b1, 1'b0,
                32'h0, 4'b0000, 32'h0, 32'hFFFFFF80, 1};
    tbl[3]  = '{OP_LH, 32'h4002, 32'h0, 32'h80011234, 1, 1'b0, 1'b0,
                32'h4000, 4'b1100, 32'h0, 32'hFFFF8001, 3};
    tbl[4]  = '{OP_LB, 32'h5001, 32'h0, 32'h11223344, 0, 1'b0, 1'b0,
                32'h5000, 4'b0010, 32'h0, 32'h00000033, 2};
    tbl[5]  = '{OP_LW, 32'h6000, 32'h0, 32'hDEADBEEF, 2, 1'b0, 1'b0,
                32'h6000, 4'b1111, 32'h0, 32'hDEADBEEF, 4};
    tbl[6]  = '{OP_SB, 32'h7002, 32'h000000A5, 32'h0, 1, 1'b0, 1'b1,
                32'h7000, 4'b0100, 32'hA5A5A5A5, 32'hDEADBEEF, 3};
    tbl[7]  = '{OP_SW, 32'h8004, 32'hCAFEF00D, 32'h0, 0, 1'b0, 1'b1,
                32'h8004, 4'b1111, 32'hCAFEF00D, 32'hDEADBEEF, 2};
    tbl[8]  = '{OP_SH, 32'h9001, 32'h0, 32'h0, 0, 1'b1, 1'b1,
                32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 1};
    tbl[9]  = '{OP_LH, 32'hA000, 32'h0, 32'hFFFF7FFE, 0, 1'b0, 1'b0,
                32'hA000, 4'b0011, 32'h0, 32'h00007FFE, 2};
    tbl[10] = '{OP_LB, 32'hB000, 32'h0, 32'h000000FF, 0, 1'b0, 1'b0,
                32'hB000, 4'b0001, 32'h0, 32'hFFFFFFFF, 2};
    tbl[11] = '{OP_LH, 32'hC003, 32'h0, 32'h0, 0, 1'b1, 1'b0,
                32'h0, 4'b0000, 32'h0, 32'hFFFFFFFF, 1};

    // Reset values, before any clock edge.
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run(tbl[i]);
    ld_exp = tbl[11].ld;

    // Illegal opcode (addi) is ignored entirely.
    r0 = req_cnt;
    d0 = done_cnt;
    @(negedge clk);
    start  = 1'b1;
    opcode = 6'b001000;
    addr   = 32'h0000_0000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ill_busy", {31'd0, busy}, 32'd0);
      chk("ill_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
    end
    chk("ill_req_cnt", req_cnt - r0, 0);
    chk("ill_done_cnt", done_cnt - d0, 0);
    chk("ill_ld", load_data, ld_exp);

    // Second start while busy is dropped.
    r0 = req_cnt;
    d0 = done_cnt;
    e.err = 1'b0;
    e.ld  = ld_exp;
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b1;
    opcode = OP_SW;
    addr   = 32'h0000_0200;
    rt_reg = 32'h0000_0011;
    @(negedge clk);
    opcode = OP_LW;
    addr   = 32'h0000_0300;
    chk("ovl_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("ovl_addr", mem_addr, 32'h200);
    chk("ovl_we", {31'd0, mem_we}, 32'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ovl_done", {31'd0, done}, 32'd1);
    e = sb.pop_front();
    chk("ovl_ld", load_data, e.ld);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("ovl_req_cnt", req_cnt - r0, 1);
    chk("ovl_done_cnt", done_cnt - d0, 1);
    chk("ovl_idle", {31'd0, busy}, 32'd0);

    // Reset mid-transfer, then a stale ack.
    d0 = done_cnt;
    @(negedge clk);
    start  = 1'b1;
    opcode = OP_LW;
    addr   = 32'h0000_0100;
    @(negedge clk);
    start = 1'b0;
    chk("rr_req", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rr_req_off", {31'd0, mem_req}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_addr", mem_addr, 32'd0);
    chk("rr_ld", load_data, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("rr_done_cnt", done_cnt - d0, 0);
    chk("rr_idle", {31'd0, busy}, 32'd0);
    chk("rr_ld_after", load_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 start  input  1  one-cycle request; opcode, addr and rt_reg are sampled on this edge.
REQ-005 opcode  input  6  MIPS opcode: lb 100000, lh 100001, lw 100011, sb 101000, sh 101001, sw 101011.
REQ-006 addr  input  32  byte address, the ALU result of rs + sign-extended immediate.
REQ-007 rt_reg  input  32  store data.
REQ-008 busy  output  1  high while a transfer is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 load_data  output  32  extended load result, valid from the done cycle until the next done.
REQ-011 addr_err  output  1  one-cycle pulse on a misaligned access, coincident with done.
REQ-012 mem_req  output  1  memory request, held until acknowledged.
REQ-013 mem_we  output  1  1 = write, 0 = read.
REQ-014 mem_addr  output  32  word address, {addr[31:2], 2'b00}.
REQ-015 mem_be  output  4  byte enables; bit i = byte lane i, where lane 0 = bits 7:0 (little-endian).
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_ack  input  1  memory completion, single cycle.
REQ-018 mem_rdata  input  32  read data, valid when mem_ack = 1.

Function
REQ-019 FSM SHALL have states IDLE, REQ, DONE; encoding is IDLE=0, REQ=1, DONE=2.
REQ-020 IDLE + start + legal aligned opcode SHALL move to REQ; mem_req is asserted the following cycle.
REQ-021 IDLE + start + misaligned access (lh/sh with addr[0]=1; lw/sw with addr[1:0]!=0) SHALL move to DONE without asserting mem_req, and SHALL leave load_data unchanged.
REQ-022 A misaligned access SHALL pulse addr_err in the DONE cycle.
REQ-023 start with an opcode outside REQ-005 SHALL be ignored; FSM stays in IDLE and no outputs change.
REQ-024 In REQ, mem_req, mem_we, mem_addr, mem_be and mem_wdata SHALL be registered and held stable until mem_ack.
REQ-025 REQ + mem_ack SHALL move to DONE and deassert mem_req in the same edge.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 Minimum latency SHALL be: start edge, then mem_req cycle (ack same cycle), then done cycle = 2 cycles after start.
REQ-028 busy SHALL equal (state != IDLE); start while busy SHALL be ignored.
REQ-029 Byte enables: byte ops SHALL set mem_be = 1<<addr[1:0]; halfword ops SHALL set 0011 (addr[1]=0) or 1100 (addr[1]=1); word ops SHALL set 1111.
REQ-030 Store data: sb SHALL drive mem_wdata = {4{rt_reg[7:0]}}; sh SHALL drive {2{rt_reg[15:0]}}; sw SHALL drive rt_reg.
REQ-031 Loads: the selected lane of mem_rdata SHALL be captured into load_data on the mem_ack edge.
REQ-032 lb SHALL sign-extend from bit 7; lh SHALL sign-extend from bit 15; stores SHALL leave load_data unchanged.
REQ-033 mem_ack outside the REQ state SHALL be ignored.

Reset
REQ-034 reset SHALL force state=IDLE, busy=0, done=0, addr_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0 and load_data=0 immediately, independent of clk.
REQ-035 Reset during REQ SHALL abandon the transfer; a mem_ack arriving after reset release SHALL be ignored per REQ-033.

Structure
REQ-036 Opcode constants (LB, LH, LW, SB, SH, SW) and FSM state encodings SHALL live in shared package mips_pkg, which is reused by the ALU and the decoder.
REQ-037 Byte-lane steering (mem_be, mem_wdata, load extract/extend) SHALL be one combinational sub-module lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-038 Case lb: addr=0x1003, mem_rdata=0x80AABBCC, ack after 3 cycles -> mem_addr=0x1000, mem_be=1000, load_data=0xFFFFFF80, done 5 cycles after start.
REQ-039 Case sh: addr=0x2002, rt_reg=0x12345678, ack immediate -> mem_we=1, mem_be=1100, mem_wdata=0x56785678, done 2 cycles after start.
REQ-040 Case lw: addr=0x3001 -> no mem_req, done=1 and addr_err=1 one cycle after start, load_data unchanged.
REQ-041 Case overlapping start: second start during REQ -> ignored; exactly one mem_req transaction and one done.
REQ-042 Case reset in REQ: assert reset with mem_req=1 -> mem_req=0 immediately; a late mem_ack produces no done.
REQ-043 Case illegal opcode: start with opcode 001000 (addi) -> busy stays 0, no mem_req, no done.
